// File: rtl/prefix_sum_out.sv
// Output stage of a parallel-prefix adder: carries, sum and flags, registered behind a
// 2-entry skid buffer. Define PREFIX_MOD_2N_M1_EN to build a modulo 2^N-1 adder instead.
module prefix_sum_out #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] h,
    input  logic [N-1:0] gg,
    input  logic [N-1:0] gp,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         zero
);

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         zero;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    // ------------------------------------------------------------------
    // Combinational result of the word currently presented upstream
    // ------------------------------------------------------------------
    logic         ec;
    logic [N:0]   carry;
    logic [N-1:0] sum_d;
    entry_t       word_d;

`ifdef PREFIX_MOD_2N_M1_EN
    // End-around carry: the group generate of the whole word feeds back as carry-in.
    logic unused_cin;
    assign unused_cin = cin;
    assign ec         = gg[N-1];
`else
    assign ec = cin;
`endif

    // Each G[i:0]/P[i:0] pair already spans bits 0..i, so every carry is one level deep.
    assign carry = {gg | (gp & {N{ec}}), ec};
    assign sum_d = h ^ carry[N-1:0];

    always_comb begin
        word_d.sum = sum_d;
`ifdef PREFIX_MOD_2N_M1_EN
        word_d.cout = 1'b0;
        word_d.zero = (sum_d == '0) || (sum_d == '1);
`else
        word_d.cout = carry[N];
        word_d.zero = (sum_d == '0);
`endif
    end

    // ------------------------------------------------------------------
    // Occupancy control
    // ------------------------------------------------------------------
    occ_t   state_q, state_d;
    entry_t main_q, skid_q;
    logic   in_xfer, out_xfer;
    logic   load_main, load_skid, main_from_skid;

    // in_ready and out_valid decode only flops, so no ready path crosses this stage.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                unique case ({in_xfer, out_xfer})
                    2'b10: begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end
                    2'b01:   state_d   = EMPTY;
                    2'b11:   load_main = 1'b1;
                    default: state_d   = ONE;
                endcase
            end
            TWO: begin
                // Skid word goes out next to keep FIFO order; input is blocked here.
                if (out_xfer) begin
                    state_d        = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) main_q <= main_from_skid ? skid_q : word_d;
            if (load_skid) skid_q <= word_d;
        end
    end

    assign sum  = main_q.sum;
    assign cout = main_q.cout;
    assign zero = main_q.zero;

endmodule

// File: doc/prefix_sum_out.md
Name: prefix_sum_out

Overview:
- Output end of the parallel-prefix adder datapath.
- Consumes per-bit half-sum h, the prefix-tree group generate G[i:0] and group propagate P[i:0] vectors, and carry-in.
- Forms carries and the final sum.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the prefix tree can be pipelined without combinational ready paths.

Parameters:
- N, 8, operand width in bits (N >= 2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  stage can accept a word.
- h  input  N  per-bit half-sum x^y.
- gg  input  N  gg[i] = group generate G[i:0].
- gp  input  N  gp[i] = group propagate P[i:0].
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  N  result.
- cout  output  1  carry-out.
- zero  output  1  sum == 0.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge.
- Reset values: out_valid=0, sum=0, cout=0, zero=0, both buffer entries empty, in_ready=1 in the cycle after reset.
- Carry rule: c[0]=cin; c[i+1] = gg[i] | (gp[i] & cin) for i=0..N-1.
- Sum and flags:
  - sum[i] = h[i] ^ c[i].
  - cout = c[N].
  - zero = (sum == 0).
  - All outputs are computed combinationally from the input word and captured together as one entry {sum,cout,zero}.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Latency: 1 cycle. A word accepted at edge k is visible on sum/cout/zero with out_valid=1 after edge k.
- Main register: holds the current output word.
  - Loaded when it is empty or being drained in the same cycle.
  - If the skid entry is full, the main register is loaded from the skid entry first (FIFO order), not from the input.
- Skid entry: captures an input word accepted while the main register is full and not being drained.
- in_ready is registered: in_ready = !skid_full. No combinational path from out_ready to in_ready.
- Occupancy states:
  - EMPTY (0 words): out_valid=0.
  - ONE (main full): out_valid=1.
  - TWO (main + skid full): out_valid=1, in_ready=0.
- Transitions:
  - EMPTY -> ONE on input transfer.
  - ONE -> TWO on input transfer without output transfer.
  - ONE -> EMPTY on output transfer without input transfer.
  - ONE stays ONE on simultaneous input and output transfers.
  - TWO -> ONE on output transfer (no input possible in TWO).
- Stall: while out_valid=1 and out_ready=0, sum/cout/zero are held stable.
- Reset mid-operation: both entries are discarded, no output transfer occurs in that cycle, and the state returns to EMPTY.
- in_valid while in_ready=0 is ignored. Upstream holds the word.
- Word integrity: no word is dropped, duplicated or reordered.

Optional Feature:
- Macro: PREFIX_MOD_2N_M1_EN.
- Defined: modulo 2^N-1 adder.
  - cin is ignored.
  - The end-around carry ec = gg[N-1] replaces cin in the carry rule: c[i+1] = gg[i] | (gp[i] & ec), c[0] = ec.
  - cout is forced to 0.
  - zero = 1 when sum is all-zeros or all-ones (both encodings of 0).
- Not defined: plain binary adder as specified above. The cin port exists in both builds.

Test Plan:
- N=8, x=0x0F, y=0x01 (h=0x0E, gg=0x0F, gp=0x0F, cin=0), out_ready=1 -> after 1 cycle: sum=0x10, cout=0, zero=0, out_valid=1.
- x=0xFF, y=0x01 (h=0xFE, gg=0xFF, gp=0xFF, cin=0) -> sum=0x00, cout=1, zero=1. With PREFIX_MOD_2N_M1_EN: sum=0x01, cout=0, zero=0.
- Back-pressure:
  - Stimulus: out_ready=0, present three words back-to-back with in_valid=1.
  - Response: words 1 and 2 accepted, in_ready=0 from the cycle after word 2 is accepted, word 3 held.
  - Then raise out_ready: the three words emerge in order, no gaps once out_ready=1.
- Full throughput: out_ready=1 with a continuous stream of 16 random words -> one result per cycle, each matching (x+y+cin) mod 256 and the carry.
- Reset mid-operation: assert rst with 2 words buffered -> next cycle out_valid=0, in_ready=1, sum=0; the buffered words never appear.
- Random stall: out_ready toggled randomly, 1000 words, scoreboard -> exact in-order match, outputs stable during stalls.
